// File: rtl/md_defs.sv
// md_defs: shared multiply/divide opcode encodings and FSM state type.
// Used by md_unit and the controller so both agree on MDOp values.
package md_defs;
    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;
endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: request/response bundle between the controller and md_unit.
// master (controller): drives start, md_op, data1 (rs), data2 (rt); reads busy, hi, lo.
// slave (md_unit): the reverse.
interface md_unit_if #(parameter int DataBit = 32);
    logic               start;
    logic [2:0]         md_op;
    logic [DataBit-1:0] data1;
    logic [DataBit-1:0] data2;
    logic               busy;
    logic [DataBit-1:0] hi;
    logic [DataBit-1:0] lo;
    modport master (output start, md_op, data1, data2, input busy, hi, lo);
    modport slave  (input start, md_op, data1, data2, output busy, hi, lo);
endinterface

// File: rtl/md_div_core.sv
// md_div_core: combinational signed/unsigned divide with defined corner cases.
// Ports: i_dividend, i_divisor (W bits), i_signed selects div vs divu;
// o_quot truncates toward zero, o_rem takes the sign of the dividend.
// Divide by zero yields quot = all ones, rem = dividend.
module md_div_core #(parameter int W = 32) (
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    input  logic         i_signed,
    output logic [W-1:0] o_quot,
    output logic [W-1:0] o_rem
);
    logic         w_neg_a;
    logic         w_neg_b;
    logic         w_zero;
    logic [W-1:0] w_abs_a;
    logic [W-1:0] w_abs_b;
    logic [W-1:0] w_uq;
    logic [W-1:0] w_ur;
    assign w_neg_a = i_signed & i_dividend[W-1];
    assign w_neg_b = i_signed & i_divisor[W-1];
    assign w_zero  = (i_divisor == '0);
    assign w_abs_a = w_neg_a ? -i_dividend : i_dividend;
    assign w_abs_b = w_neg_b ? -i_divisor : i_divisor;
    assign w_uq    = w_zero ? '0 : w_abs_a / w_abs_b;
    assign w_ur    = w_zero ? '0 : w_abs_a % w_abs_b;
    // -2^(W-1) / -1 needs no special path: the magnitude 2^(W-1) fits unsigned,
    // the quotient 2^(W-1) negates back to itself and the remainder is 0.
    assign o_quot  = w_zero ? '1 : ((w_neg_a ^ w_neg_b) ? -w_uq : w_uq);
    assign o_rem   = w_zero ? i_dividend : (w_neg_a ? -w_ur : w_ur);
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers (EX stage).
// Ports: i_clk; i_reset_n (synchronous, active-low); md (slave side of md_unit_if):
// start/md_op/data1/data2 in, busy/hi/lo out. busy is high for exactly N cycles
// after an accepted mult/div; HI/LO update on the commit edge.
module md_unit
    import md_defs::*;
#(
    parameter int DataBit    = 32,
    parameter int MultCycles = 5,
    parameter int DivCycles  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    md_unit_if.slave    md
);
    localparam int MaxCycles = (MultCycles > DivCycles) ? MultCycles : DivCycles;
    localparam int CntBit    = $clog2(MaxCycles + 1);
    localparam logic [CntBit-1:0] MultLoad = CntBit'(MultCycles - 1);
    localparam logic [CntBit-1:0] DivLoad  = CntBit'(DivCycles - 1);

    md_state_e          r_state;
    md_state_e          w_state_nx;
    logic [CntBit-1:0]  r_cnt;
    logic [CntBit-1:0]  w_cnt_nx;
    logic [DataBit-1:0] r_a;
    logic [DataBit-1:0] r_b;
    logic [2:0]         r_op;
    logic [DataBit-1:0] r_hi;
    logic [DataBit-1:0] r_lo;
    logic [DataBit-1:0] w_hi_nx;
    logic [DataBit-1:0] w_lo_nx;
    logic               w_load;
    logic               w_is_mul;
    logic               w_signed;
    logic [2*DataBit-1:0] w_ext_a;
    logic [2*DataBit-1:0] w_ext_b;
    logic [2*DataBit-1:0] w_prod;
    logic [DataBit-1:0] w_quot;
    logic [DataBit-1:0] w_rem;

    assign w_is_mul = (r_op == MD_MULT) || (r_op == MD_MULTU);
    assign w_signed = (r_op == MD_MULT) || (r_op == MD_DIV);
    // Sign- or zero-extend to 2W so the low 2W bits of one product serve both mult and multu.
    assign w_ext_a  = {{DataBit{r_a[DataBit-1] & w_signed}}, r_a};
    assign w_ext_b  = {{DataBit{r_b[DataBit-1] & w_signed}}, r_b};
    assign w_prod   = w_ext_a * w_ext_b;

    md_div_core #(.W(DataBit)) u_div (
        .i_dividend (r_a),
        .i_divisor  (r_b),
        .i_signed   (w_signed),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_load     = 1'b0;
        if (r_state == ST_IDLE) begin
            if (md.start) begin
                if (md.md_op == MD_MTHI) w_hi_nx = md.data1;
                if (md.md_op == MD_MTLO) w_lo_nx = md.data1;
                if (md.md_op == MD_MULT || md.md_op == MD_MULTU || md.md_op == MD_DIV || md.md_op == MD_DIVU) begin
                    w_load     = 1'b1;
                    w_state_nx = ST_RUN;
                    w_cnt_nx   = md.md_op[1] ? DivLoad : MultLoad;
                end
            end
        end else if (r_cnt != '0) begin
            w_cnt_nx = r_cnt - 1'b1;
        end else begin
            w_state_nx = ST_IDLE;
            w_hi_nx    = w_is_mul ? w_prod[2*DataBit-1:DataBit] : w_rem;
            w_lo_nx    = w_is_mul ? w_prod[DataBit-1:0] : w_quot;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            if (w_load) begin
                r_a  <= md.data1;
                r_b  <= md.data2;
                r_op <= md.md_op;
            end
        end
    end

    assign md.busy = (r_state == ST_RUN);
    assign md.hi   = r_hi;
    assign md.lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized self-checking bench for md_unit against a 64-bit arithmetic model.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    md_unit_if #(.DataBit(32)) bus ();

    md_unit #(.DataBit(32), .MultCycles(MC), .DivCycles(DC)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .md        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: results from plain 64-bit arithmetic, latency from the parameters.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        longint x;
        longint y;
        logic [63:0] p;
        n = 0;
        case (op)
            3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); {exp_hi, exp_lo} = p; n = MC; end
            3'd1: begin p = {32'h0, a} * {32'h0, b}; {exp_hi, exp_lo} = p; n = MC; end
            3'd2, 3'd3: begin
                n = DC;
                if (b == 0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                end else begin
                    x = (op == 3'd2) ? longint'($signed(a)) : longint'({32'h0, a});
                    y = (op == 3'd2) ? longint'($signed(b)) : longint'({32'h0, b});
                    exp_lo = 32'(x / y);
                    exp_hi = 32'(x % y);
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: n = 0;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int n;
        int cnt;
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(op, a, b, n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.data1 = a;
        bus.data2 = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            if (cnt == 0) begin
                check("stale_hi", bus.hi, old_hi);
                check("stale_lo", bus.lo, old_lo);
            end
            cnt++;
            @(posedge clk);
            #1;
        end
        check("busy_len", cnt, n);
        check("hi", bus.hi, exp_hi);
        check("lo", bus.lo, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int cnt;
        bus.start = 1'b0;
        bus.md_op = '0;
        bus.data1 = '0;
        bus.data2 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_busy", bus.busy, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi_const", bus.hi, 64'hFFFF_FFFF);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        check("multu_hi_const", bus.hi, 64'h2);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_const", bus.lo, 64'hFFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd0);
        check("divu0_hi_const", bus.hi, 64'h7);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf_lo_const", bus.lo, 64'h8000_0000);

        // Start arriving during busy must be ignored entirely.
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'd0; bus.data1 = 32'd4; bus.data2 = 32'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.md_op = 3'd4; bus.data1 = 32'h1234;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cnt = 3;
        while (bus.busy && cnt < 100) begin cnt++; @(posedge clk); #1; end
        check("ign_busy_len", cnt, MC);
        exp_hi = 32'h0;
        exp_lo = 32'd20;
        check("ign_hi", bus.hi, exp_hi);
        check("ign_lo", bus.lo, exp_lo);
        run_op(3'd5, 32'hABCD, 32'h0);

        for (int i = 0; i < 60; i++) run_op(3'($urandom_range(0, 7)), pick(), pick());
        run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);

        // Reset during the 4th busy cycle of a divide discards it.
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'd2; bus.data1 = 32'd100; bus.data2 = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("mrst_busy", bus.busy, 0);
        check("mrst_hi", bus.hi, 0);
        check("mrst_lo", bus.lo, 0);
        repeat (15) begin @(posedge clk); #1; end
        check("late_busy", bus.busy, 0);
        check("late_hi", bus.hi, 0);
        check("late_lo", bus.lo, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the pipelined CPU.
- Sits in the EX stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from the controller and raises Busy while a long operation runs, so the hazard logic can stall.
- Adds behaviour the single-cycle datapath lacks: configurable latency, a busy handshake, and defined results for divide corner cases.

Parameters:
- DataBit, 32, operand and HI/LO width (even, >=8).
- MultCycles, 5, busy cycles for mult/multu (>=1).
- DivCycles, 10, busy cycles for div/divu (>=1).

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-low; Reset=0 at a rising edge clears all state.
- Start  input  1  operation request, qualified by MDOp.
- MDOp  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others are no-op.
- Data1  input  DataBit  rs operand / mthi-mtlo source.
- Data2  input  DataBit  rt operand.
- Busy  output  1  registered; high while a mult/div is in flight.
- HI  output  DataBit  HI register.
- LO  output  DataBit  LO register.

Behaviour:
- Reset (Reset=0 at an edge): Busy=0, HI=0, LO=0, counter=0, operand latches=0. This applies mid-operation too: the in-flight result is discarded and HI/LO stay 0.
- Accept condition: Start=1 and Busy=0 at an edge. Start while Busy=1 is ignored entirely, with no effect on HI/LO or the counter.
- mthi/mtlo when accepted: HI (or LO) <= Data1 at that edge. Busy stays 0, latency 1.
- mult/multu/div/divu when accepted:
  - Latch operands and op.
  - Busy<=1, counter<=N-1, where N = MultCycles or DivCycles.
- While Busy=1, each edge:
  - If counter!=0: counter decrements.
  - If counter==0: HI/LO <= result and Busy<=0.
  - Busy is therefore high for exactly N cycles after the accept edge. New HI/LO are visible in the first cycle with Busy=0.
- A new Start is accepted in the same cycle Busy first reads 0 (back-to-back allowed).
- HI/LO hold their old values throughout Busy; reads during Busy return the stale values. Stalling mfhi/mflo is the hazard unit's job.
- Results (width W=DataBit):
  - mult: {HI,LO} = signed(Data1) * signed(Data2), 2W-bit two's complement.
  - multu: same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
  - divu: same, unsigned.
- Divide corner cases:
  - Divide by zero (div or divu): LO = all ones, HI = dividend.
  - Signed overflow, div with Data1 = -2^(W-1) and Data2 = -1: LO = -2^(W-1), HI = 0.
- Undefined MDOp with Start=1: no-op, Busy stays 0.
- FSM states:
  - IDLE (Busy=0) -> RUN on an accepted mult/div.
  - RUN -> RUN while counter!=0.
  - RUN -> IDLE on the commit edge.
  - Any state -> IDLE on reset.
- Implementation may compute combinationally from latched operands at commit, or iteratively, provided the cycle count and results match the above.

Decomposition:
- Shared package md_defs: MDOp encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO) and the FSM state constants.
- The controller imports the same encodings.
- One natural sub-module, md_div_core: signed/unsigned divide with the zero and overflow rules, producing quotient and remainder. Multiply stays inline.

Test Plan:
- Reset=0 for 2 cycles, then Reset=1 -> Busy=0, HI=0, LO=0.
- mult, Data1=0xFFFFFFFE (-2), Data2=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div, Data1=-7 (0xFFFFFFF9), Data2=2 -> Busy 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu, 7/0 -> LO=0xFFFFFFFF, HI=0x00000007.
- div, Data1=0x80000000, Data2=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start mult 4*5; during the 3rd Busy cycle pulse Start+mthi with Data1=0x1234 -> ignored; commit gives HI=0, LO=20. Next cycle mtlo 0xABCD -> LO=0xABCD, Busy stays 0.
- Start div 100/7; at the 4th Busy cycle drive Reset=0 -> Busy=0, HI=LO=0 next cycle, and no later commit occurs.
